// File: rtl/contador_reloj_fecha_pkg.sv
// Shared field codes, limits and month constants for the clock/calendar counter.
package contador_reloj_fecha_pkg;

  localparam logic [2:0] CAMPO_SEG  = 3'd0;
  localparam logic [2:0] CAMPO_MIN  = 3'd1;
  localparam logic [2:0] CAMPO_HORA = 3'd2;
  localparam logic [2:0] CAMPO_DIA  = 3'd3;
  localparam logic [2:0] CAMPO_MES  = 3'd4;
  localparam logic [2:0] CAMPO_YEAR = 3'd5;

  localparam logic [5:0] MAX_SEG  = 6'd59;
  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [4:0] MAX_HORA = 5'd23;
  localparam logic [3:0] MAX_MES  = 4'd12;
  localparam logic [4:0] MAX_YEAR = 5'd31;

  localparam logic [3:0] MES_ENE = 4'd1;
  localparam logic [3:0] MES_FEB = 4'd2;
  localparam logic [3:0] MES_ABR = 4'd4;
  localparam logic [3:0] MES_JUN = 4'd6;
  localparam logic [3:0] MES_SEP = 4'd9;
  localparam logic [3:0] MES_NOV = 4'd11;

  // Year count is an offset from 2000, so every multiple of 4 is a leap year.
  function automatic logic es_bisiesto(input logic [4:0] year);
    return (year & 5'd3) == 5'd0;
  endfunction

endpackage

// File: rtl/contador_reloj_fecha_if.sv
// Edit bus from the keyboard/edit controller into the clock/calendar counter.
interface contador_reloj_fecha_if;
  logic       edit_valid;
  logic [2:0] edit_campo;
  logic [6:0] edit_valor;
  logic       edit_err;

  modport master (
    output edit_valid,
    output edit_campo,
    output edit_valor,
    input  edit_err
  );

  modport slave (
    input  edit_valid,
    input  edit_campo,
    input  edit_valor,
    output edit_err
  );
endinterface

// File: rtl/contador_reloj_fecha_dias_del_mes.sv
// Days in a month for a given month/year count; purely combinational.
module dias_del_mes
  import contador_reloj_fecha_pkg::*;
(
  input  logic [3:0] mes,
  input  logic [4:0] year,
  output logic [4:0] dim
);

  always_comb begin
    dim = 5'd31;
    case (mes)
      MES_ABR, MES_JUN, MES_SEP, MES_NOV: dim = 5'd30;
      MES_FEB: dim = es_bisiesto(year) ? 5'd29 : 5'd28;
      default: dim = 5'd31;
    endcase
  end

endmodule

// File: rtl/contador_reloj_fecha.sv
// Real-time clock/calendar: one-second prescaler, cascaded time/date counters
// and single-field edit port with range checking and day clamping.
module contador_reloj_fecha
  import contador_reloj_fecha_pkg::*;
#(
  parameter int unsigned DIV      = 100000000,
  parameter int unsigned YEAR_RST = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_cuenta,
  contador_reloj_fecha_if.slave edit,
  output logic [5:0]            Cuenta_Segundos,
  output logic [5:0]            Cuenta_Minutos,
  output logic [4:0]            Cuenta_Horas,
  output logic [6:0]            Cuenta_Dia,
  output logic [3:0]            Cuenta_Mes,
  output logic [4:0]            Cuenta_Year,
  output logic                  tick_seg
);

  localparam int unsigned    PW        = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          pend_q, pend_d;
  logic [5:0]    seg_q, seg_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hora_q, hora_d;
  logic [4:0]    dia_q, dia_d;
  logic [3:0]    mes_q, mes_d;
  logic [4:0]    year_q, year_d;
  logic          tick_q, tick_d;
  logic          err_q, err_d;

  logic       tick_raw, tick_do;
  logic       edit_ok, edit_apply, seg_edit;
  logic [6:0] valor;
  logic [2:0] campo;
  logic [3:0] mes_cand;
  logic [4:0] year_cand;
  logic [4:0] dim_act, dim_cand;

  assign valor = edit.edit_valor;
  assign campo = edit.edit_campo;

  // Candidate month/year used to validate day edits and to clamp the day on month/year edits.
  assign mes_cand  = (campo == CAMPO_MES)  ? valor[3:0] : mes_q;
  assign year_cand = (campo == CAMPO_YEAR) ? valor[4:0] : year_q;

  dias_del_mes u_dim_act (
    .mes  (mes_q),
    .year (year_q),
    .dim  (dim_act)
  );

  dias_del_mes u_dim_cand (
    .mes  (mes_cand),
    .year (year_cand),
    .dim  (dim_cand)
  );

  assign tick_raw = en_cuenta && (presc_q == PRESC_MAX);

  always_comb begin
    edit_ok = 1'b0;
    case (campo)
      CAMPO_SEG:  edit_ok = valor <= 7'(MAX_SEG);
      CAMPO_MIN:  edit_ok = valor <= 7'(MAX_MIN);
      CAMPO_HORA: edit_ok = valor <= 7'(MAX_HORA);
      CAMPO_DIA:  edit_ok = (valor >= 7'd1) && (valor <= 7'(dim_cand));
      CAMPO_MES:  edit_ok = (valor >= 7'd1) && (valor <= 7'(MAX_MES));
      CAMPO_YEAR: edit_ok = valor <= 7'(MAX_YEAR);
      default:    edit_ok = 1'b0;
    endcase
  end

  assign edit_apply = edit.edit_valid && edit_ok;
  assign seg_edit   = edit_apply && (campo == CAMPO_SEG);
  // Any edit strobe defers the tick; it is replayed from pend_q on the next quiet cycle.
  assign tick_do    = !edit.edit_valid && (tick_raw || pend_q);

  always_comb begin
    presc_d = presc_q;
    pend_d  = edit.edit_valid && (tick_raw || pend_q) && !seg_edit;
    seg_d   = seg_q;
    min_d   = min_q;
    hora_d  = hora_q;
    dia_d   = dia_q;
    mes_d   = mes_q;
    year_d  = year_q;
    tick_d  = tick_do;
    err_d   = edit.edit_valid && !edit_ok;

    if (seg_edit) begin
      presc_d = '0;
    end else if (en_cuenta) begin
      presc_d = tick_raw ? '0 : presc_q + 1'b1;
    end

    if (tick_do) begin
      seg_d = seg_q + 6'd1;
      if (seg_q == MAX_SEG) begin
        seg_d = '0;
        min_d = min_q + 6'd1;
        if (min_q == MAX_MIN) begin
          min_d  = '0;
          hora_d = hora_q + 5'd1;
          if (hora_q == MAX_HORA) begin
            hora_d = '0;
            dia_d  = dia_q + 5'd1;
            if (dia_q >= dim_act) begin
              dia_d = 5'd1;
              mes_d = mes_q + 4'd1;
              if (mes_q >= MAX_MES) begin
                mes_d  = MES_ENE;
                year_d = (year_q == MAX_YEAR) ? '0 : year_q + 5'd1;
              end
            end
          end
        end
      end
    end else if (edit_apply) begin
      case (campo)
        CAMPO_SEG:  seg_d  = valor[5:0];
        CAMPO_MIN:  min_d  = valor[5:0];
        CAMPO_HORA: hora_d = valor[4:0];
        CAMPO_DIA:  dia_d  = valor[4:0];
        CAMPO_MES: begin
          mes_d = valor[3:0];
          if (dia_q > dim_cand) dia_d = dim_cand;
        end
        CAMPO_YEAR: begin
          year_d = valor[4:0];
          if (dia_q > dim_cand) dia_d = dim_cand;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      pend_q  <= 1'b0;
      seg_q   <= '0;
      min_q   <= '0;
      hora_q  <= '0;
      dia_q   <= 5'd1;
      mes_q   <= MES_ENE;
      year_q  <= 5'(YEAR_RST);
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      pend_q  <= pend_d;
      seg_q   <= seg_d;
      min_q   <= min_d;
      hora_q  <= hora_d;
      dia_q   <= dia_d;
      mes_q   <= mes_d;
      year_q  <= year_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
    end
  end

  assign Cuenta_Segundos = seg_q;
  assign Cuenta_Minutos  = min_q;
  assign Cuenta_Horas    = hora_q;
  assign Cuenta_Dia      = {2'b00, dia_q};
  assign Cuenta_Mes      = mes_q;
  assign Cuenta_Year     = year_q;
  assign tick_seg        = tick_q;
  assign edit.edit_err   = err_q;

endmodule

// File: tb/tb_contador_reloj_fecha.sv
// Directed bench for contador_reloj_fecha with DIV=4 and YEAR_RST=16.
module tb_contador_reloj_fecha;

  logic       clk = 1'b0;
  logic       reset;
  logic       en_cuenta;
  logic [5:0] seg, min;
  logic [4:0] hora;
  logic [6:0] dia;
  logic [3:0] mes;
  logic [4:0] year;
  logic       tick_seg;

  int unsigned checks = 0;
  int unsigned errors = 0;

  contador_reloj_fecha_if eif ();

  contador_reloj_fecha #(.DIV(4), .YEAR_RST(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .en_cuenta       (en_cuenta),
    .edit            (eif),
    .Cuenta_Segundos (seg),
    .Cuenta_Minutos  (min),
    .Cuenta_Horas    (hora),
    .Cuenta_Dia      (dia),
    .Cuenta_Mes      (mes),
    .Cuenta_Year     (year),
    .tick_seg        (tick_seg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_edit(input logic [2:0] c, input logic [6:0] v);
    eif.edit_valid = 1'b1;
    eif.edit_campo = c;
    eif.edit_valor = v;
    step();
    eif.edit_valid = 1'b0;
  endtask

  task automatic run_tick();
    int unsigned n;
    n = 0;
    en_cuenta = 1'b1;
    do begin
      step();
      n++;
    end while (!tick_seg && n < 12);
    en_cuenta = 1'b0;
    checks++;
    if (tick_seg !== 1'b1) begin
      errors++;
      $display("FAIL tick_wait: tick_seg=%b after %0d cycles, required 1", tick_seg, n);
    end
  endtask

  task automatic test_reset();
    int unsigned nt;
    reset = 1'b1; en_cuenta = 1'b0;
    eif.edit_valid = 1'b0; eif.edit_campo = '0; eif.edit_valor = '0;
    repeat (3) step();
    checks++;
    if ({hora, min, seg, dia, mes, year} !== {5'd0, 6'd0, 6'd0, 7'd1, 4'd1, 5'd16}) begin
      errors++;
      $display("FAIL reset_fields: %0d:%0d:%0d %0d/%0d/%0d, required 0:0:0 1/1/16",
               hora, min, seg, dia, mes, year);
    end
    checks++;
    if ({tick_seg, eif.edit_err} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: tick=%b err=%b, required 0 0", tick_seg, eif.edit_err);
    end
    reset = 1'b0;
    en_cuenta = 1'b1;
    nt = 0;
    repeat (8) begin
      step();
      if (tick_seg === 1'b1) nt++;
    end
    en_cuenta = 1'b0;
    checks++;
    if (nt != 2) begin
      errors++;
      $display("FAIL run8_ticks: got %0d pulses, required 2", nt);
    end
    checks++;
    if ({hora, min, seg, dia, mes, year} !== {5'd0, 6'd0, 6'd2, 7'd1, 4'd1, 5'd16}) begin
      errors++;
      $display("FAIL run8_fields: %0d:%0d:%0d %0d/%0d/%0d, required 0:0:2 1/1/16",
               hora, min, seg, dia, mes, year);
    end
  endtask

  task automatic test_year_rollover();
    do_edit(3'd2, 7'd23);
    do_edit(3'd1, 7'd59);
    do_edit(3'd0, 7'd59);
    do_edit(3'd3, 7'd31);
    do_edit(3'd4, 7'd12);
    do_edit(3'd5, 7'd31);
    checks++;
    if ({hora, min, seg, dia, mes, year, eif.edit_err} !== {5'd23, 6'd59, 6'd59, 7'd31, 4'd12, 5'd31, 1'b0}) begin
      errors++;
      $display("FAIL edit_load: %0d:%0d:%0d %0d/%0d/%0d err=%b, required 23:59:59 31/12/31 err=0",
               hora, min, seg, dia, mes, year, eif.edit_err);
    end
    run_tick();
    checks++;
    if ({hora, min, seg, dia, mes, year} !== {5'd0, 6'd0, 6'd0, 7'd1, 4'd1, 5'd0}) begin
      errors++;
      $display("FAIL year_wrap: %0d:%0d:%0d %0d/%0d/%0d, required 0:0:0 1/1/0",
               hora, min, seg, dia, mes, year);
    end
  endtask

  task automatic test_febrero();
    do_edit(3'd5, 7'd16);
    do_edit(3'd4, 7'd2);
    do_edit(3'd3, 7'd28);
    do_edit(3'd2, 7'd23);
    do_edit(3'd1, 7'd59);
    do_edit(3'd0, 7'd59);
    run_tick();
    checks++;
    if ({hora, min, seg, dia, mes, year} !== {5'd0, 6'd0, 6'd0, 7'd29, 4'd2, 5'd16}) begin
      errors++;
      $display("FAIL leap_feb28: %0d:%0d:%0d %0d/%0d/%0d, required 0:0:0 29/2/16",
               hora, min, seg, dia, mes, year);
    end
    do_edit(3'd5, 7'd17);
    checks++;
    if ({dia, year} !== {7'd28, 5'd17}) begin
      errors++;
      $display("FAIL year_clamp: day=%0d year=%0d, required day=28 year=17", dia, year);
    end
    do_edit(3'd3, 7'd28);
    do_edit(3'd2, 7'd23);
    do_edit(3'd1, 7'd59);
    do_edit(3'd0, 7'd59);
    run_tick();
    checks++;
    if ({hora, min, seg, dia, mes, year} !== {5'd0, 6'd0, 6'd0, 7'd1, 4'd3, 5'd17}) begin
      errors++;
      $display("FAIL common_feb28: %0d:%0d:%0d %0d/%0d/%0d, required 0:0:0 1/3/17",
               hora, min, seg, dia, mes, year);
    end
  endtask

  task automatic test_clamp();
    do_edit(3'd4, 7'd1);
    do_edit(3'd3, 7'd31);
    do_edit(3'd4, 7'd4);
    checks++;
    if ({mes, dia, eif.edit_err} !== {4'd4, 7'd30, 1'b0}) begin
      errors++;
      $display("FAIL month_clamp: month=%0d day=%0d err=%b, required 4 30 0", mes, dia, eif.edit_err);
    end
    do_edit(3'd3, 7'd31);
    checks++;
    if ({eif.edit_err, dia} !== {1'b1, 7'd30}) begin
      errors++;
      $display("FAIL day31_reject: err=%b day=%0d, required err=1 day=30", eif.edit_err, dia);
    end
    step();
    checks++;
    if (eif.edit_err !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse_width: err=%b, required 0", eif.edit_err);
    end
  endtask

  task automatic test_edit_tick_collision();
    int unsigned nt;
    do_edit(3'd0, 7'd10);
    en_cuenta = 1'b1;
    repeat (3) step();
    do_edit(3'd1, 7'd5);
    en_cuenta = 1'b0;
    checks++;
    if ({min, seg, tick_seg} !== {6'd5, 6'd10, 1'b0}) begin
      errors++;
      $display("FAIL collide_edit: min=%0d sec=%0d tick=%b, required 5 10 0", min, seg, tick_seg);
    end
    nt = 0;
    step();
    if (tick_seg === 1'b1) nt++;
    checks++;
    if ({seg, tick_seg} !== {6'd11, 1'b1}) begin
      errors++;
      $display("FAIL collide_pending: sec=%0d tick=%b, required 11 1", seg, tick_seg);
    end
    repeat (3) begin
      step();
      if (tick_seg === 1'b1) nt++;
    end
    checks++;
    if (nt != 1 || seg !== 6'd11) begin
      errors++;
      $display("FAIL collide_count: pulses=%0d sec=%0d, required 1 11", nt, seg);
    end
  endtask

  task automatic test_invalid_edits();
    logic [2:0] bad_c [4];
    logic [6:0] bad_v [4];
    bad_c = '{3'd6, 3'd0, 3'd2, 3'd4};
    bad_v = '{7'd3, 7'd60, 7'd24, 7'd0};
    for (int i = 0; i < 4; i++) begin
      do_edit(bad_c[i], bad_v[i]);
      checks++;
      if ({eif.edit_err, hora, min, seg, dia, mes, year} !==
          {1'b1, 5'd0, 6'd5, 6'd11, 7'd30, 4'd4, 5'd17}) begin
        errors++;
        $display("FAIL bad_edit[%0d] c=%0d v=%0d: err=%b %0d:%0d:%0d %0d/%0d/%0d, required err=1 0:5:11 30/4/17",
                 i, bad_c[i], bad_v[i], eif.edit_err, hora, min, seg, dia, mes, year);
      end
    end
  endtask

  task automatic test_reset_pending();
    int unsigned nt;
    do_edit(3'd0, 7'd20);
    en_cuenta = 1'b1;
    repeat (3) step();
    do_edit(3'd1, 7'd7);
    en_cuenta = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({hora, min, seg, dia, mes, year, tick_seg} !== {5'd0, 6'd0, 6'd0, 7'd1, 4'd1, 5'd16, 1'b0}) begin
      errors++;
      $display("FAIL reset_pending: %0d:%0d:%0d %0d/%0d/%0d tick=%b, required 0:0:0 1/1/16 tick=0",
               hora, min, seg, dia, mes, year, tick_seg);
    end
    nt = 0;
    repeat (4) begin
      step();
      if (tick_seg === 1'b1) nt++;
    end
    checks++;
    if (nt != 0 || seg !== 6'd0) begin
      errors++;
      $display("FAIL reset_abort: pulses=%0d sec=%0d, required 0 0", nt, seg);
    end
  endtask

  initial begin
    test_reset();
    test_year_rollover();
    test_febrero();
    test_clamp();
    test_edit_tick_collision();
    test_invalid_edits();
    test_reset_pending();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/contador_reloj_fecha.md
Name: contador_reloj_fecha

Overview:
- Real-time clock/calendar counter that produces the Cuenta_Segundos/Minutos/Horas/Dia/Mes/Year binary counts.
- These counts feed the time/date display multiplexer directly downstream.
- Advances once per second from an internal clk prescaler.
- Accepts single-field write strobes from the keyboard/edit controller so the user can set time and date.

Parameters:
- DIV, 100000000, clk cycles per one-second tick (bench uses 4).
- YEAR_RST, 16, reset value of year count (2000 + count).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- en_cuenta  input  1  1 = prescaler runs; 0 = time frozen, edits still accepted
- edit_valid  input  1  one-cycle write strobe
- edit_campo  input  3  field select: 0 sec, 1 min, 2 hour, 3 day, 4 month, 5 year; 6–7 invalid
- edit_valor  input  7  binary value to write
- Cuenta_Segundos  output  6  0..59
- Cuenta_Minutos  output  6  0..59
- Cuenta_Horas  output  5  0..23
- Cuenta_Dia  output  7  1..31, upper bits always 0
- Cuenta_Mes  output  4  1..12
- Cuenta_Year  output  5  0..31
- tick_seg  output  1  one-cycle pulse when seconds advance
- edit_err  output  1  one-cycle pulse: rejected edit

Behaviour:
- All outputs are registered.
- Reset: sec/min/hour 0, day 1, month 1, year YEAR_RST, prescaler 0, pending 0, tick_seg 0, edit_err 0.
- Reset mid-operation aborts any pending tick.
- Prescaler:
  - Counts 0..DIV-1 while en_cuenta=1 and holds while en_cuenta=0.
  - On the cycle it equals DIV-1 it wraps to 0 and raises the internal tick.
- Tick effect: counts update on the clock edge after the tick cycle; tick_seg is asserted in the same cycle the new seconds value appears.
- Cascade on tick:
  - sec 59→0 carries to min; min 59→0 carries to hour; hour 23→0 carries to day.
  - Day at dim (days in month) →1 carries to month; month 12→1 carries to year; year 31→0, no flag.
- dim rules:
  - Months 4, 6, 9, 11 → 30.
  - Month 2 → 29 if year[1:0]==0, else 28.
  - All other months → 31.
- Edit:
  - Valid range per field: sec/min 0..59, hour 0..23, day 1..dim(current month/year), month 1..12, year 0..31.
  - In range → field loaded next cycle.
  - Out of range or campo 6/7 → no change, edit_err=1 next cycle.
- Clamp: a month or year edit that makes the current day > new dim forces day := new dim in the same update.
- Seconds edit clears the prescaler to 0 and discards any pending tick.
- Edit and tick in the same cycle:
  - The edit wins.
  - The tick is held in a pending flag and applied on the next cycle with no edit, so no second is lost.
  - Only one tick is ever pending, since DIV ≥ 2 guarantees it.
  - A tick with no edit applies immediately.
- Widths: all comparisons are in native field width; Cuenta_Dia[6:5] is constant 0.

Decomposition:
- Shared package holds:
  - field codes (CAMPO_SEG..CAMPO_YEAR)
  - limits (MAX_SEG=59, MAX_HORA=23, MAX_MES=12, MAX_YEAR=31)
  - month constants
- Natural sub-module: dias_del_mes, combinational, (mes[3:0], year[4:0]) → dim[4:0]. It is used for both the cascade and edit validation.

Test Plan (DIV=4):
- Reset, then en_cuenta=1 for 8 cycles → two tick_seg pulses, sec=2, all other fields at reset values.
- Edit hour=23, min=59, sec=59, day=31, month=12, year=31, then one tick → time 00:00:00, day=1, month=1, year=0.
- Year=16, month=2, day=28, time 23:59:59, one tick → day=29, month=2; repeat with year=17 → day=1, month=3.
- Day=31, month=1, then edit month=4 → month=4 and day clamps to 30; edit day=31 → edit_err pulse, day stays 30.
- Edit min=5 in exactly the tick cycle with sec=10 → min=5 next cycle, sec=11 one cycle later, exactly one tick_seg.
- Edit campo=6 → edit_err=1, no field change. Edit sec=60 → edit_err=1. Assert reset with a tick pending → all fields at reset values, no tick_seg afterwards.
